// File: rtl/fb_pkg.sv
// Shared constants, state encoding and CRC step for the FreeDM bus receive path.
package fb_pkg;

  localparam logic [3:0] NIB_PRE = 4'h5;
  localparam logic [3:0] NIB_SFD = 4'hD;

  localparam logic [7:0] CRC_INIT    = 8'hFF;
  localparam logic [7:0] CRC_TAPS    = 8'hA7;
  localparam logic [7:0] CRC_RESIDUE = 8'h7B;

  // RxStatus bit positions
  localparam int STAT_TOO_SHORT  = 3;
  localparam int STAT_TOO_LONG   = 2;
  localparam int STAT_ODD_NIBBLE = 1;
  localparam int STAT_CRC_ERR    = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_DATA = 2'd2,
    ST_DROP = 2'd3
  } rx_state_t;

  // One nibble through the CRC shift register, MSB of the nibble first.
  function automatic logic [7:0] crc_nibble(input logic [7:0] crc, input logic [3:0] data);
    logic [7:0] c;
    logic       fb;
    c = crc;
    for (int i = 3; i >= 0; i--) begin
      fb = c[7] ^ data[i];
      c  = {c[6:0], 1'b0} ^ (fb ? CRC_TAPS : 8'h00);
    end
    return c;
  endfunction

endpackage

// File: rtl/fb_crc.sv
// Nibble-wide CRC-8 accumulator; CrcError flags a register value other than the good-frame residue.
module fb_crc
  import fb_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Initialize,
  input  logic       Enable,
  input  logic [3:0] Data,
  output logic [7:0] Crc,
  output logic       CrcError
);

  // Initialize has priority over Enable so the SFD cycle always starts a clean CRC.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      Crc <= CRC_INIT;
    else if (Initialize)
      Crc <= CRC_INIT;
    else if (Enable)
      Crc <= crc_nibble(Crc, Data);
  end

  assign CrcError = (Crc != CRC_RESIDUE);

endmodule

// File: rtl/fb_rx_frame.sv
// FreeDM slave receive framer: strips preamble/SFD, assembles bytes, withholds the CRC byte.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | bus quiet, waiting for the first preamble nibble
// PRE     | counting 0x5 preamble nibbles, waiting for SFD 0xD
// DATA    | frame body: nibbles into CRC, bytes held one deep and emitted
// DROP    | malformed start, ignoring the bus until RxDv falls
module fb_rx_frame
  import fb_pkg::*;
#(
  parameter int PRE_MIN   = 2,
  parameter int MAX_BYTES = 64,
  parameter int MIN_BYTES = 2
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [3:0] RxD,
  input  logic       RxDv,
  output logic [7:0] RxByte,
  output logic       RxValid,
  output logic       RxStart,
  output logic       RxDone,
  output logic [7:0] RxLen,
  output logic [3:0] RxStatus
);

  localparam logic [7:0] PRE_MIN_C = 8'(PRE_MIN);
  localparam logic [8:0] MAX_C     = 9'(MAX_BYTES);
  localparam logic [8:0] MIN_C     = 9'(MIN_BYTES);

  rx_state_t  state, state_nxt;
  logic [7:0] pre_cnt, pre_cnt_nxt;
  logic [3:0] hi_nib, hi_nib_nxt;
  logic       half, half_nxt;
  logic [7:0] held, held_nxt;
  logic       held_vld, held_vld_nxt;
  logic [8:0] body_cnt, body_cnt_nxt;
  logic       too_long, too_long_nxt;
  logic [7:0] byte_nxt, len_nxt;
  logic       valid_nxt, start_nxt, done_nxt;
  logic [3:0] status_nxt;
  logic       sfd_ok, crc_en, crc_err;
  logic [7:0] crc_value;
  logic       crc_unused;
  logic [8:0] len_raw, len_cap;

  fb_crc u_crc (
    .Clk        (Clk),
    .Reset      (~Reset_n),
    .Initialize (sfd_ok | ~Reset_n),
    .Enable     (crc_en),
    .Data       (RxD),
    .Crc        (crc_value),
    .CrcError   (crc_err)
  );

  // The raw CRC register is only interesting on a debug probe.
  assign crc_unused = ^crc_value;

  // Payload length excludes the CRC byte and never reports more than MAX_BYTES-1.
  assign len_raw = (body_cnt == 9'd0) ? 9'd0 : body_cnt - 9'd1;
  assign len_cap = (len_raw > MAX_C - 9'd1) ? MAX_C - 9'd1 : len_raw;

  // State, counters and registered outputs.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state    <= ST_IDLE;
      pre_cnt  <= '0;
      hi_nib   <= '0;
      half     <= 1'b0;
      held     <= '0;
      held_vld <= 1'b0;
      body_cnt <= '0;
      too_long <= 1'b0;
      RxByte   <= '0;
      RxValid  <= 1'b0;
      RxStart  <= 1'b0;
      RxDone   <= 1'b0;
      RxLen    <= '0;
      RxStatus <= '0;
    end else begin
      state    <= state_nxt;
      pre_cnt  <= pre_cnt_nxt;
      hi_nib   <= hi_nib_nxt;
      half     <= half_nxt;
      held     <= held_nxt;
      held_vld <= held_vld_nxt;
      body_cnt <= body_cnt_nxt;
      too_long <= too_long_nxt;
      RxByte   <= byte_nxt;
      RxValid  <= valid_nxt;
      RxStart  <= start_nxt;
      RxDone   <= done_nxt;
      RxLen    <= len_nxt;
      RxStatus <= status_nxt;
    end
  end

  // Next-state decode, byte assembly and end-of-frame status.
  always_comb begin
    state_nxt    = state;
    pre_cnt_nxt  = pre_cnt;
    hi_nib_nxt   = hi_nib;
    half_nxt     = half;
    held_nxt     = held;
    held_vld_nxt = held_vld;
    body_cnt_nxt = body_cnt;
    too_long_nxt = too_long;
    byte_nxt     = RxByte;
    valid_nxt    = 1'b0;
    start_nxt    = 1'b0;
    done_nxt     = 1'b0;
    len_nxt      = RxLen;
    status_nxt   = RxStatus;
    sfd_ok       = 1'b0;
    crc_en       = 1'b0;

    case (state)
      ST_IDLE: begin
        if (RxDv) begin
          if (RxD == NIB_PRE) begin
            state_nxt   = ST_PRE;
            pre_cnt_nxt = 8'd1;
          end else begin
            state_nxt = ST_DROP;
          end
        end
      end
      ST_PRE: begin
        if (!RxDv) begin
          state_nxt   = ST_IDLE;
          pre_cnt_nxt = '0;
        end else if (RxD == NIB_PRE) begin
          if (pre_cnt != 8'hFF)
            pre_cnt_nxt = pre_cnt + 8'd1;
        end else if (RxD == NIB_SFD && pre_cnt >= PRE_MIN_C) begin
          state_nxt    = ST_DATA;
          sfd_ok       = 1'b1;
          start_nxt    = 1'b1;
          pre_cnt_nxt  = '0;
          half_nxt     = 1'b0;
          held_vld_nxt = 1'b0;
          body_cnt_nxt = '0;
          too_long_nxt = 1'b0;
        end else begin
          state_nxt   = ST_DROP;
          pre_cnt_nxt = '0;
        end
      end
      ST_DATA: begin
        if (RxDv) begin
          crc_en = 1'b1;
          if (!half) begin
            hi_nib_nxt = RxD;
            half_nxt   = 1'b1;
          end else begin
            half_nxt = 1'b0;
            if (body_cnt <= MAX_C)
              body_cnt_nxt = body_cnt + 9'd1;
            if (body_cnt >= MAX_C)
              too_long_nxt = 1'b1;
            // The held byte goes out only while the new count is still within bounds.
            if (held_vld && body_cnt < MAX_C) begin
              valid_nxt = 1'b1;
              byte_nxt  = held;
            end
            held_nxt     = {hi_nib, RxD};
            held_vld_nxt = 1'b1;
          end
        end else begin
          // The held byte is the CRC and is discarded here.
          state_nxt                  = ST_IDLE;
          done_nxt                   = 1'b1;
          len_nxt                    = 8'(len_cap);
          status_nxt                 = '0;
          status_nxt[STAT_TOO_SHORT]  = (body_cnt < MIN_C);
          status_nxt[STAT_TOO_LONG]   = too_long;
          status_nxt[STAT_ODD_NIBBLE] = half;
          status_nxt[STAT_CRC_ERR]    = crc_err;
        end
      end
      ST_DROP: begin
        if (!RxDv)
          state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fb_rx_frame.sv
// Scoreboard bench for fb_rx_frame: frames are modelled as nibble lists and
// the expected start/byte/done events are queued before each frame is driven.
module tb_fb_rx_frame;

  localparam int PRE_MIN   = 2;
  localparam int MAX_BYTES = 4;
  localparam int MIN_BYTES = 2;

  typedef logic [3:0] nib_t;
  typedef struct {
    int         kind;   // 0 start, 1 byte, 2 done
    logic [7:0] val;
    logic [3:0] st;
  } ev_t;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic [3:0] RxD = 4'h0;
  logic       RxDv = 1'b0;
  logic [7:0] RxByte, RxLen;
  logic       RxValid, RxStart, RxDone;
  logic [3:0] RxStatus;

  int checks = 0;
  int failures = 0;

  ev_t        sb[$];
  nib_t       fr[$];
  logic [7:0] dat[$];
  int         npre_cur;

  always #5 Clk = ~Clk;

  fb_rx_frame #(
    .PRE_MIN   (PRE_MIN),
    .MAX_BYTES (MAX_BYTES),
    .MIN_BYTES (MIN_BYTES)
  ) dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .RxD      (RxD),
    .RxDv     (RxDv),
    .RxByte   (RxByte),
    .RxValid  (RxValid),
    .RxStart  (RxStart),
    .RxDone   (RxDone),
    .RxLen    (RxLen),
    .RxStatus (RxStatus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] crc_nib(input logic [7:0] c, input nib_t d);
    logic [7:0] r;
    logic       fb;
    r = c;
    for (int b = 3; b >= 0; b--) begin
      fb = r[7] ^ d[b];
      r  = {r[6:0], 1'b0};
      if (fb) r = r ^ 8'hA7;
    end
    return r;
  endfunction

  function automatic logic [7:0] crc_fix(input logic [7:0] s);
    logic [7:0] cand;
    for (int v = 0; v < 256; v++) begin
      cand = 8'(v);
      if (crc_nib(crc_nib(s, cand[7:4]), cand[3:0]) == 8'h7B) return cand;
    end
    return 8'h00;
  endfunction

  function automatic nib_t not5();
    int v;
    v = $urandom_range(0, 14);
    if (v >= 5) v++;
    return 4'(v);
  endfunction

  // Builds preamble + SFD + dat + a CRC byte that makes the residue come out right.
  task automatic make_good(input int npre);
    logic [7:0] s, c;
    fr = {};
    npre_cur = npre;
    repeat (npre) fr.push_back(4'h5);
    fr.push_back(4'hD);
    s = 8'hFF;
    foreach (dat[i]) begin
      fr.push_back(dat[i][7:4]);
      fr.push_back(dat[i][3:0]);
      s = crc_nib(crc_nib(s, dat[i][7:4]), dat[i][3:0]);
    end
    c = crc_fix(s);
    fr.push_back(c[7:4]);
    fr.push_back(c[3:0]);
  endtask

  // Reference: interpret the whole nibble list of one RxDv envelope.
  task automatic model_push();
    int         i, pc, nb, nbytes, nlen;
    logic       odd;
    logic [7:0] c;
    ev_t        e;
    i  = 0;
    pc = 0;
    if (fr.size() == 0 || fr[0] != 4'h5) return;
    while (i < fr.size() && fr[i] == 4'h5) begin
      pc++;
      i++;
    end
    if (i >= fr.size() || fr[i] != 4'hD || pc < PRE_MIN) return;
    i++;
    e.kind = 0; e.val = 8'h00; e.st = 4'h0;
    sb.push_back(e);
    nb     = fr.size() - i;
    nbytes = nb / 2;
    odd    = (nb % 2) != 0;
    c = 8'hFF;
    for (int k = i; k < fr.size(); k++) c = crc_nib(c, fr[k]);
    for (int k = 0; k < nbytes - 1 && k < MAX_BYTES - 1; k++) begin
      e.kind = 1;
      e.val  = {fr[i + 2 * k], fr[i + 2 * k + 1]};
      sb.push_back(e);
    end
    nlen = (nbytes == 0) ? 0 : nbytes - 1;
    if (nlen > MAX_BYTES - 1) nlen = MAX_BYTES - 1;
    e.kind = 2;
    e.val  = 8'(nlen);
    e.st   = {nbytes < MIN_BYTES, nbytes > MAX_BYTES, odd, c != 8'h7B};
    sb.push_back(e);
  endtask

  task automatic cyc(input logic v, input nib_t d);
    RxDv = v;
    RxD  = d;
    @(posedge Clk);
    #1;
  endtask

  task automatic send(input int gap);
    model_push();
    foreach (fr[k]) cyc(1'b1, fr[k]);
    repeat (gap) cyc(1'b0, 4'h0);
  endtask

  task automatic rand_good();
    int n, p;
    n = $urandom_range(0, 5);
    dat = {};
    repeat (n) dat.push_back(8'($urandom));
    make_good($urandom_range(2, 5));
    if ($urandom_range(0, 3) == 0) begin
      p = $urandom_range(npre_cur + 1, fr.size() - 1);
      fr[p] = fr[p] ^ 4'(1 << $urandom_range(0, 3));
    end
    if ($urandom_range(0, 4) == 0) fr.push_back(4'($urandom));
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  initial begin : monitor
    logic       rst_edge;
    logic [7:0] last_len;
    logic [3:0] last_st;
    ev_t        e;
    last_len = 8'h00;
    last_st  = 4'h0;
    forever begin
      @(posedge Clk);
      rst_edge = !Reset_n;
      @(negedge Clk);
      if (rst_edge) begin
        chk("reset_outputs", {RxByte, RxValid, RxStart, RxDone, RxLen, RxStatus}, 32'h0);
        last_len = 8'h00;
        last_st  = 4'h0;
      end else begin
        chk("valid_done_exclusive", 32'(RxValid & RxDone), 32'h0);
        if (RxStart) begin
          chk("start_expected", 32'(sb.size() > 0), 32'h1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("start_kind", e.kind, 0);
          end
        end
        if (RxValid) begin
          chk("byte_expected", 32'(sb.size() > 0), 32'h1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("byte_kind", e.kind, 1);
            chk("rx_byte", RxByte, e.val);
          end
        end
        if (RxDone) begin
          chk("done_expected", 32'(sb.size() > 0), 32'h1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("done_kind", e.kind, 2);
            chk("rx_len", RxLen, e.val);
            chk("rx_status", RxStatus, e.st);
          end
          last_len = RxLen;
          last_st  = RxStatus;
        end else begin
          chk("len_hold", RxLen, last_len);
          chk("status_hold", RxStatus, last_st);
        end
      end
    end
  end

  initial begin : stimulus
    ev_t e;
    int  kind, n;
    RxDv    = 1'b0;
    RxD     = 4'h0;
    Reset_n = 1'b0;
    repeat (3) @(posedge Clk);
    #1 Reset_n = 1'b1;
    cyc(1'b0, 4'h0);

    // Known-good frame
    dat = '{8'h12, 8'h34, 8'hAB};
    make_good(4);
    send(2);

    // Corrupted body byte 0x34 -> 0x35, CRC kept from the good frame
    make_good(4);
    fr[8] = 4'h5;
    send(2);

    // Trailing half byte
    make_good(4);
    fr.push_back(4'h0);
    send(2);

    // Broken preamble, then a good frame
    fr = '{4'h5, 4'h7, 4'hD, 4'h1, 4'h2, 4'h3, 4'h4};
    send(1);
    dat = '{8'h5A, 8'hC3};
    make_good(2);
    send(1);

    // Body longer than MAX_BYTES
    dat = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    make_good(2);
    send(2);

    // CRC byte only
    dat = {};
    make_good(3);
    send(2);

    // Reset in the middle of the body, then a good frame
    dat = '{8'h12, 8'h34, 8'hAB};
    make_good(4);
    e.kind = 0; e.val = 8'h00; e.st = 4'h0;
    sb.push_back(e);
    for (int k = 0; k < 7; k++) cyc(1'b1, fr[k]);
    Reset_n = 1'b0;
    cyc(1'b1, fr[7]);
    Reset_n = 1'b1;
    cyc(1'b1, 4'h0);
    cyc(1'b1, 4'h0);
    cyc(1'b0, 4'h0);
    cyc(1'b0, 4'h0);
    make_good(4);
    send(2);

    // Randomized mix of good, corrupted and malformed frames
    for (int t = 0; t < 150; t++) begin
      kind = $urandom_range(0, 9);
      if (kind <= 5) begin
        rand_good();
      end else if (kind == 6) begin
        fr = '{4'h5};
        fr.push_back(not5());
        n = $urandom_range(0, 6);
        repeat (n) fr.push_back(4'($urandom));
      end else if (kind == 7) begin
        fr = {};
        fr.push_back(not5());
        n = $urandom_range(0, 6);
        repeat (n) fr.push_back(4'($urandom));
      end else if (kind == 8) begin
        fr = '{4'h5, 4'hD};
        n = $urandom_range(0, 6);
        repeat (n) fr.push_back(4'($urandom));
      end else begin
        fr = {};
        n = $urandom_range(1, 4);
        repeat (n) fr.push_back(4'h5);
      end
      send($urandom_range(1, 3));
    end

    // Let the last frame's events arrive, bounded.
    for (int w = 0; w < 20 && sb.size() != 0; w++) cyc(1'b0, 4'h0);
    chk("scoreboard_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
